// File: rtl/ram_large_ctrl.sv
// Request-side controller for the 16Kx16 banked sync RAM: valid/ready request and response channels, RAM pin sequencing.
// Optional feature macro RAM_CTRL_STATS_EN adds saturating rd_count/wr_count outputs.
module ram_large_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  wr_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
`ifdef RAM_CTRL_STATS_EN
    ,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_RSP  = 3'd4;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic w_accept;
    logic w_mem_active;

    assign w_accept     = req_valid && req_ready;
    assign w_mem_active = (r_state == S_WR) || (r_state == S_RD) || (r_state == S_CAP);

    // NOTE: every register here is reset synchronously, so the reset branch lives inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_state <= req_we ? S_WR : S_RD;
                    end
                end
                S_WR:  r_state <= S_IDLE;
                S_RD:  r_state <= S_CAP;
                S_CAP: begin
                    // The RAM presents the word registered at the end of RD during this cycle.
                    r_rdata <= mem_data;
                    r_state <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = rst_n && (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RSP);
    assign rsp_rdata = r_rdata;
    assign wr_done   = (r_state == S_WR);

    assign mem_cs   = w_mem_active;
    assign mem_we   = (r_state == S_WR);
    assign mem_oe   = (r_state == S_RD) || (r_state == S_CAP);
    assign mem_addr = w_mem_active ? r_addr : '0;
    // Drive the bus only while writing so it never overlaps the RAM's read drive.
    assign mem_data = (r_state == S_WR) ? r_wdata : 'z;

`ifdef RAM_CTRL_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if ((r_state == S_WR) && (r_wr_count != 16'hFFFF))
                r_wr_count <= r_wr_count + 16'd1;
            if ((r_state == S_RSP) && rsp_ready && (r_rd_count != 16'hFFFF))
                r_rd_count <= r_rd_count + 16'd1;
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_ram_large_ctrl.sv
// Self-checking bench for ram_large_ctrl: behavioural RAM on the pins, array reference model, directed and random ops.
module tb_ram_large_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        wr_done;
    logic [13:0] mem_addr;
    wire  [15:0] mem_data;
    logic        mem_cs;
    logic        mem_we;
    logic        mem_oe;
`ifdef RAM_CTRL_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    ram_large_ctrl #(.ADDR_WIDTH(14), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .wr_done(wr_done), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
`ifdef RAM_CTRL_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural sync RAM on the pins, plus a probe that drives a known pattern when nobody else should.
    logic [15:0] ram [0:16383];
    logic [15:0] ram_q = 16'h0;
    logic        probe_en = 1'b0;
    wire         ram_drv = mem_cs && mem_oe && !mem_we;
    assign mem_data = ram_drv ? ram_q : (probe_en ? 16'h5A5A : 16'hzzzz);

    always @(posedge clk) begin
        if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
        if (mem_cs && mem_oe && !mem_we) ram_q <= ram[mem_addr];
    end

    // Reference model: what each address should hold, and how many ops the stats should report.
    logic [15:0] model_mem [int];
    int n_checks = 0;
    int n_errors = 0;
    int accept_cyc = 0;
    int exp_wr = 0;
    int exp_rd = 0;

    function automatic logic [15:0] model_rd(input int a);
        if (model_mem.exists(a)) return model_mem[a];
        return 16'h0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_req();
        req_we    = 1'($urandom);
        req_addr  = 14'($urandom);
        req_wdata = 16'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int budget = 0;
        while (req_ready !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin n_errors++; $display("FAIL %s_ready_timeout req_ready=%b exp=1", tag, req_ready); end
    endtask

    task automatic probe_bus(input string tag);
        probe_en = 1'b1;
        #1;
        n_checks++;
        if (mem_data !== 16'h5A5A) begin n_errors++; $display("FAIL %s_bus_not_released mem_data=%h exp=5a5a", tag, mem_data); end
        probe_en = 1'b0;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [15:0] d);
        wait_idle("wr");
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        tick();
        accept_cyc = cyc;
        req_valid = 1'b0;
        scramble_req();
        n_checks++; if (wr_done !== 1'b1) begin n_errors++; $display("FAIL wr_done_pulse got=%b exp=1", wr_done); end
        n_checks++; if ({mem_cs, mem_we, mem_oe} !== 3'b110) begin n_errors++; $display("FAIL wr_ctl cs/we/oe got=%b exp=110", {mem_cs, mem_we, mem_oe}); end
        n_checks++; if (mem_addr !== a) begin n_errors++; $display("FAIL wr_addr got=%h exp=%h", mem_addr, a); end
        n_checks++; if (mem_data !== d) begin n_errors++; $display("FAIL wr_data got=%h exp=%h", mem_data, d); end
        n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL wr_req_ready got=%b exp=0", req_ready); end
        model_mem[int'(a)] = d;
        exp_wr++;
        tick();
        n_checks++; if (wr_done !== 1'b0) begin n_errors++; $display("FAIL wr_done_width got=%b exp=0", wr_done); end
        n_checks++; if (req_ready !== 1'b1 || mem_cs !== 1'b0) begin n_errors++; $display("FAIL wr_return_idle ready=%b cs=%b exp=1/0", req_ready, mem_cs); end
    endtask

    task automatic do_read(input logic [13:0] a, input int hold);
        logic [15:0] exp_d;
        exp_d = model_rd(int'(a));
        wait_idle("rd");
        // Non-zero latched wdata makes any stray controller drive during CAP corrupt the captured word.
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 16'($urandom_range(1, 65535));
        rsp_ready = (hold == 0);
        tick();
        accept_cyc = cyc;
        req_valid = 1'b0;
        scramble_req();
        n_checks++; if ({mem_cs, mem_we, mem_oe} !== 3'b101) begin n_errors++; $display("FAIL rd_ctl cs/we/oe got=%b exp=101", {mem_cs, mem_we, mem_oe}); end
        n_checks++; if (mem_addr !== a) begin n_errors++; $display("FAIL rd_addr got=%h exp=%h", mem_addr, a); end
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || wr_done !== 1'b0) begin n_errors++; $display("FAIL rd_phase_flags valid=%b ready=%b wr_done=%b exp=000", rsp_valid, req_ready, wr_done); end
        tick();
        n_checks++; if ({mem_cs, mem_we, mem_oe} !== 3'b101 || mem_addr !== a) begin n_errors++; $display("FAIL cap_ctl cs/we/oe=%b addr=%h exp=101/%h", {mem_cs, mem_we, mem_oe}, mem_addr, a); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL cap_rsp_valid got=%b exp=0", rsp_valid); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || cyc - accept_cyc != 2) begin n_errors++; $display("FAIL rd_latency valid=%b edges=%0d exp=1/2", rsp_valid, cyc - accept_cyc); end
        n_checks++; if (rsp_rdata !== exp_d) begin n_errors++; $display("FAIL rd_data @%h got=%h exp=%h", a, rsp_rdata, exp_d); end
        n_checks++; if (mem_cs !== 1'b0 || mem_addr !== 14'h0 || req_ready !== 1'b0) begin n_errors++; $display("FAIL rsp_pins cs=%b addr=%h ready=%b exp=0/0/0", mem_cs, mem_addr, req_ready); end
        probe_bus("rsp");
        for (int i = 0; i < hold; i++) begin
            tick();
            n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_d) begin n_errors++; $display("FAIL rsp_hold cyc%0d valid=%b data=%h exp=1/%h", i, rsp_valid, rsp_rdata, exp_d); end
            n_checks++; if (req_ready !== 1'b0 || mem_cs !== 1'b0) begin n_errors++; $display("FAIL rsp_hold_pins cyc%0d ready=%b cs=%b exp=0/0", i, req_ready, mem_cs); end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_rd++;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_errors++; $display("FAIL rsp_release valid=%b ready=%b exp=0/1", rsp_valid, req_ready); end
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        exp_wr = 0;
        exp_rd = 0;
    endtask

    task automatic test_reset();
        apply_reset(3);
        n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0 || wr_done !== 1'b0) begin n_errors++; $display("FAIL reset_flags valid=%b wr_done=%b exp=0/0", rsp_valid, wr_done); end
        n_checks++; if ({mem_cs, mem_we, mem_oe} !== 3'b000 || mem_addr !== 14'h0) begin n_errors++; $display("FAIL reset_pins cs/we/oe=%b addr=%h exp=000/0", {mem_cs, mem_we, mem_oe}, mem_addr); end
        n_checks++; if (rsp_rdata !== 16'h0) begin n_errors++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
        probe_bus("reset");
`ifdef RAM_CTRL_STATS_EN
        n_checks++; if (rd_count !== 16'h0 || wr_count !== 16'h0) begin n_errors++; $display("FAIL reset_stats rd=%0d wr=%0d exp=0/0", rd_count, wr_count); end
`endif
        rst_n = 1'b1;
        tick();
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_basic();
        do_write(14'h0000, 16'hBEEF);
        do_read(14'h0000, 0);
    endtask

    task automatic test_banks();
        do_write(14'h0005, 16'h1111);
        do_write(14'h1005, 16'h2222);
        do_write(14'h2005, 16'h3333);
        do_write(14'h3005, 16'h4444);
        do_read(14'h0005, 0);
        do_read(14'h1005, 1);
        do_read(14'h2005, 0);
        do_read(14'h3005, 2);
    endtask

    task automatic test_top_word();
        do_write(14'h3FFF, 16'hA5C3);
        do_read(14'h3FFF, 0);
        n_checks++; if (rsp_rdata[15:8] !== 8'hA5 || rsp_rdata[7:0] !== 8'hC3) begin n_errors++; $display("FAIL byte_lanes hi=%h lo=%h exp=a5/c3", rsp_rdata[15:8], rsp_rdata[7:0]); end
    endtask

    task automatic test_rsp_backpressure();
        do_read(14'h1005, 5);
    endtask

    task automatic test_back_to_back();
        int first_acc;
        do_write(14'h0123, 16'h0F0F);
        first_acc = accept_cyc;
        do_write(14'h0124, 16'hF0F0);
        n_checks++; if (accept_cyc - first_acc != 2) begin n_errors++; $display("FAIL b2b_write_spacing got=%0d exp=2", accept_cyc - first_acc); end
        do_read(14'h0123, 0);
        do_read(14'h0124, 0);
    endtask

    task automatic test_mid_reset();
        wait_idle("midrst");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h0000; req_wdata = 16'h7777;
        rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        n_checks++; if ({mem_cs, mem_we, mem_oe} !== 3'b101) begin n_errors++; $display("FAIL midrst_in_cap cs/we/oe=%b exp=101", {mem_cs, mem_we, mem_oe}); end
        rst_n = 1'b0;
        tick();
        exp_wr = 0;
        exp_rd = 0;
        n_checks++; if (rsp_valid !== 1'b0 || mem_cs !== 1'b0 || req_ready !== 1'b0) begin n_errors++; $display("FAIL midrst_state valid=%b cs=%b ready=%b exp=0/0/0", rsp_valid, mem_cs, req_ready); end
        n_checks++; if (rsp_rdata !== 16'h0) begin n_errors++; $display("FAIL midrst_rdata got=%h exp=0", rsp_rdata); end
        probe_bus("midrst");
        rst_n = 1'b1;
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_dropped valid=%b ready=%b exp=0/1", rsp_valid, req_ready); end
        do_read(14'h0000, 0);
    endtask

    task automatic test_random();
        logic [13:0] a;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 14'h0000;
                1:       a = 14'h3FFF;
                default: a = 14'($urandom_range(0, 16383));
            endcase
            if ($urandom_range(0, 1) == 1) do_write(a, 16'($urandom));
            else                           do_read(a, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_stats();
`ifdef RAM_CTRL_STATS_EN
        apply_reset(2);
        rst_n = 1'b1;
        tick();
        do_write(14'h0010, 16'h1234);
        do_write(14'h2010, 16'h5678);
        do_write(14'h3FFE, 16'h9ABC);
        do_read(14'h0010, 0);
        do_read(14'h3FFE, 2);
        n_checks++; if (wr_count !== 16'(exp_wr) || wr_count !== 16'd3) begin n_errors++; $display("FAIL stats_wr got=%0d exp=3", wr_count); end
        n_checks++; if (rd_count !== 16'(exp_rd) || rd_count !== 16'd2) begin n_errors++; $display("FAIL stats_rd got=%0d exp=2", rd_count); end
        apply_reset(1);
        n_checks++; if (wr_count !== 16'h0 || rd_count !== 16'h0) begin n_errors++; $display("FAIL stats_clear wr=%0d rd=%0d exp=0/0", wr_count, rd_count); end
        rst_n = 1'b1;
        tick();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 16'h0000;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_banks();
        test_top_word();
        test_rsp_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_random();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
